conv2_seq: RTL and testbench

//  Sequencer for the second convolution layer. Walks output rows x filters x input channels x kernel rows.

---
 rtl/conv2_seq_pkg.sv | 37 +++
 rtl/conv2_addr_gen.sv | 29 ++
 rtl/conv2_seq.sv | 162 ++++++++++++++++
 tb/tb_conv2_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv2_seq_pkg.sv
// Shared definitions for the conv2 sequencer.
//   Layer geometry (rows, channels, filters, kernel rows).
//   Address widths for the feature buffer and the weight ROM.
//   Widths of the loop counters.
//   FSM state encoding.
//   The per-step decode record produced by the address generator.
package conv2_seq_pkg;

  localparam int IN_ROWS = 28;  // rows per input map == output rows
  localparam int N_CH    = 2;   // input channels
  localparam int N_FILT  = 4;   // filters
  localparam int K       = 3;   // kernel rows, one ROM row per step
  localparam int FA_W    = 6;   // feature-buffer address width
  localparam int WA_W    = 5;   // weight-ROM address width

  localparam int ROW_W = $clog2(IN_ROWS);
  localparam int F_W   = $clog2(N_FILT);
  localparam int CH_W  = $clog2(N_CH);
  localparam int KR_W  = $clog2(K);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Everything the issue stage needs to know about one (row, f, ch, kr) step.
  typedef struct packed {
    logic [FA_W-1:0] fa;     // feature-buffer row address (0 on pad taps)
    logic [WA_W-1:0] wa;     // weight-ROM row address
    logic            pad;    // input row falls outside the map
    logic            clear;  // first step of a filter
    logic            last;   // last step of a filter
  } step_info_t;

endpackage

// File: rtl/conv2_addr_gen.sv
// Combinational step decoder for the conv2 sequencer.
//   i_row, i_f, i_ch, i_kr : current loop counters
//   o_info                 : buffer and ROM addresses, plus pad/clear/last flags
module conv2_addr_gen
  import conv2_seq_pkg::*;
(
  input  logic [ROW_W-1:0] i_row,
  input  logic [F_W-1:0]   i_f,
  input  logic [CH_W-1:0]  i_ch,
  input  logic [KR_W-1:0]  i_kr,
  output step_info_t       o_info
);

  // The input row is row+kr-1. Here it is held as row+kr, which is one too
  // high, so the top-pad case is 0 and the value never has to be signed.
  logic [FA_W-1:0] w_row_plus_kr;
  logic            w_pad;

  assign w_row_plus_kr = FA_W'(i_row) + FA_W'(i_kr);
  assign w_pad         = (w_row_plus_kr == '0) || (w_row_plus_kr > FA_W'(IN_ROWS));

  assign o_info.pad   = w_pad;
  assign o_info.fa    = w_pad ? '0
                              : FA_W'(i_ch) * FA_W'(IN_ROWS) + w_row_plus_kr - FA_W'(1);
  assign o_info.wa    = (WA_W'(i_f) * WA_W'(N_CH) + WA_W'(i_ch)) * WA_W'(K) + WA_W'(i_kr);
  assign o_info.clear = (i_ch == '0) && (i_kr == '0);
  assign o_info.last  = (i_ch == CH_W'(N_CH - 1)) && (i_kr == KR_W'(K - 1));

endmodule

// File: rtl/conv2_seq.sv
// Sequencer for the second convolution layer. One MAC step is issued per RUN
// cycle, walking kr (innermost), then ch, then f, then row.
//   clk, rst (async, active-low)
//   start / busy / done        : handshake with the top-level FSM
//   dst_full                   : pooling stage back-pressure, honoured only between filters
//   fbuf_rd_en/addr, w_rd_addr : issue-stage reads (1-cycle synchronous memories)
//   mac_en/clear/last/pad, b_sel, out_row : strobes registered one cycle after
//                                           issue, so they line up with read data
module conv2_seq
  import conv2_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dst_full,
  output logic             busy,
  output logic             done,
  output logic             fbuf_rd_en,
  output logic [FA_W-1:0]  fbuf_rd_addr,
  output logic [WA_W-1:0]  w_rd_addr,
  output logic [F_W-1:0]   b_sel,
  output logic             mac_en,
  output logic             mac_clear,
  output logic             mac_last,
  output logic             mac_pad,
  output logic [ROW_W-1:0] out_row
);

  state_t           r_state;
  logic [ROW_W-1:0] r_row;
  logic [F_W-1:0]   r_f;
  logic [CH_W-1:0]  r_ch;
  logic [KR_W-1:0]  r_kr;
  logic             r_busy;
  logic             r_done;

  logic             r_mac_en;
  logic             r_mac_clear;
  logic             r_mac_last;
  logic             r_mac_pad;
  logic [F_W-1:0]   r_b_sel;
  logic [ROW_W-1:0] r_out_row;

  step_info_t w_info;
  logic       w_boundary;
  logic       w_issue;
  logic       w_final;

  conv2_addr_gen u_addr_gen (
    .i_row  (r_row),
    .i_f    (r_f),
    .i_ch   (r_ch),
    .i_kr   (r_kr),
    .o_info (w_info)
  );

  // Back-pressure is honoured only at a filter boundary. A filter that has
  // started always runs to mac_last, so an accumulation is never split.
  assign w_boundary = (r_ch == '0) && (r_kr == '0);
  assign w_issue    = (r_state == S_RUN) && !(w_boundary && dst_full);
  assign w_final    = (r_row == ROW_W'(IN_ROWS - 1)) && (r_f == F_W'(N_FILT - 1)) &&
                      (r_ch == CH_W'(N_CH - 1)) && (r_kr == KR_W'(K - 1));

  // Addresses are forced to 0 when nothing is issued, so the memory ports
  // stay quiet in IDLE and while stalled.
  assign fbuf_rd_en   = w_issue && !w_info.pad;
  assign fbuf_rd_addr = w_issue ? w_info.fa : '0;
  assign w_rd_addr    = w_issue ? w_info.wa : '0;

  // NOTE: state is updated with non-blocking assignments only. Every branch
  // then reads the values from before the clock edge, whatever the order of
  // the statements.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_f     <= '0;
      r_ch    <= '0;
      r_kr    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            if (w_final) begin
              r_state <= S_DRAIN;
              r_row   <= '0;
              r_f     <= '0;
              r_ch    <= '0;
              r_kr    <= '0;
            end else if (r_kr != KR_W'(K - 1)) begin
              r_kr <= r_kr + KR_W'(1);
            end else begin
              r_kr <= '0;
              if (r_ch != CH_W'(N_CH - 1)) begin
                r_ch <= r_ch + CH_W'(1);
              end else begin
                r_ch <= '0;
                if (r_f != F_W'(N_FILT - 1)) begin
                  r_f <= r_f + F_W'(1);
                end else begin
                  r_f   <= '0;
                  r_row <= r_row + ROW_W'(1);
                end
              end
            end
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_row   <= '0;
          r_f     <= '0;
          r_ch    <= '0;
          r_kr    <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // This stage delays the strobes by one cycle, to match the memory read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mac_en    <= 1'b0;
      r_mac_clear <= 1'b0;
      r_mac_last  <= 1'b0;
      r_mac_pad   <= 1'b0;
      r_b_sel     <= '0;
      r_out_row   <= '0;
    end else begin
      r_mac_en    <= w_issue;
      r_mac_clear <= w_issue && w_info.clear;
      r_mac_last  <= w_issue && w_info.last;
      r_mac_pad   <= w_issue && w_info.pad;
      r_b_sel     <= w_issue ? r_f : '0;
      r_out_row   <= w_issue ? r_row : '0;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign mac_en    = r_mac_en;
  assign mac_clear = r_mac_clear;
  assign mac_last  = r_mac_last;
  assign mac_pad   = r_mac_pad;
  assign b_sel     = r_b_sel;
  assign out_row   = r_out_row;

endmodule

// File: tb/tb_conv2_seq.sv
// Self-checking bench for conv2_seq. The expected step stream is generated
// from the loop nest and queued when start is driven. Each mac_en beat pops
// one entry and compares it. The bench also checks timing, back-pressure,
// mid-pass reset and start filtering.
module tb_conv2_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dst_full;
  logic       busy, done, fbuf_rd_en, mac_en, mac_clear, mac_last, mac_pad;
  logic [5:0] fbuf_rd_addr;
  logic [4:0] w_rd_addr;
  logic [1:0] b_sel;
  logic [4:0] out_row;

  conv2_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dst_full     (dst_full),
    .busy         (busy),
    .done         (done),
    .fbuf_rd_en   (fbuf_rd_en),
    .fbuf_rd_addr (fbuf_rd_addr),
    .w_rd_addr    (w_rd_addr),
    .b_sel        (b_sel),
    .mac_en       (mac_en),
    .mac_clear    (mac_clear),
    .mac_last     (mac_last),
    .mac_pad      (mac_pad),
    .out_row      (out_row)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] strobe;  // {out_row, b_sel, clear, last, pad}
    logic [31:0] issue;   // {rd_en, fa, wa} seen one cycle before the beat
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int s_cyc;
  int en_count, first_en_cyc, last_en_cyc, done_cyc, done_cnt, gap_beat;

  logic       prev_en;
  logic [5:0] prev_fa;
  logic [4:0] prev_wa;

  wire [24:0] w_all = {busy, done, fbuf_rd_en, fbuf_rd_addr, w_rd_addr, b_sel,
                       mac_en, mac_clear, mac_last, mac_pad, out_row};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected stream for one full pass, derived from the loop nest.
  task automatic push_pass();
    exp_t e;
    int   in_r;
    bit   pad;
    for (int row = 0; row < 28; row++)
      for (int f = 0; f < 4; f++)
        for (int ch = 0; ch < 2; ch++)
          for (int kr = 0; kr < 3; kr++) begin
            in_r     = row + kr - 1;
            pad      = (in_r < 0) || (in_r >= 28);
            e.strobe = 32'({5'(row), 2'(f), (ch == 0 && kr == 0), (ch == 1 && kr == 2), pad});
            e.issue  = 32'({!pad, 6'(pad ? 0 : ch * 28 + in_r), 5'((f * 2 + ch) * 3 + kr)});
            sb.push_back(e);
          end
  endtask

  task automatic new_pass();
    en_count = 0; first_en_cyc = -1; last_en_cyc = -1;
    done_cyc = -1; done_cnt = 0; gap_beat = -1;
    s_cyc    = cyc;
    push_pass();
  endtask

  // Each beat is checked against the scoreboard, and a few boundary beats
  // against fixed constants.
  always @(negedge clk) begin
    exp_t e;
    if (mac_en) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("strobe", 32'({out_row, b_sel, mac_clear, mac_last, mac_pad}), e.strobe);
        check("issue", 32'({prev_en, prev_fa, prev_wa}), e.issue);
      end
      case (en_count)
        0:   check("r0_kr0_pad", 32'({mac_pad, prev_en}), 32'b10);
        1:   check("r0_kr1_addr", 32'(prev_fa), 32'd0);
        2:   check("r0_kr2_addr", 32'(prev_fa), 32'd1);
        6:   check("f1_clear", 32'({prev_wa, mac_clear}), 32'({5'd6, 1'b1}));
        11:  check("f1_last", 32'({prev_wa, mac_last, b_sel}), 32'({5'd11, 1'b1, 2'd1}));
        651: check("r27_ch1_kr0_addr", 32'(prev_fa), 32'd54);
        653: check("r27_ch1_kr2_pad", 32'({mac_pad, prev_en}), 32'b10);
        default: ;
      endcase
      if (en_count == 0) first_en_cyc = cyc;
      last_en_cyc = cyc;
      en_count++;
    end else if (en_count > 0 && en_count < 672 && gap_beat < 0) begin
      gap_beat = en_count;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_en = fbuf_rd_en;
    prev_fa = fbuf_rd_addr;
    prev_wa = w_rd_addr;
  end

  task automatic wait_cyc(input int target);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < target);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    new_pass();
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_timeout", 32'(done_cnt > 0), 32'd1);
  endtask

  // Called in the cycle after done, which is IDLE again.
  task automatic check_pass(input string tag, input int exp_first, input int exp_span);
    check({tag, "_beats"}, 32'(en_count), 32'd672);
    check({tag, "_first_en"}, 32'(first_en_cyc), 32'(exp_first));
    check({tag, "_span"}, 32'(last_en_cyc - first_en_cyc + 1), 32'(exp_span));
    check({tag, "_done_at"}, 32'(done_cyc), 32'(last_en_cyc + 1));
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int d;
    rst = 1'b0; start = 1'b0; dst_full = 1'b0;
    #2;
    check("reset_outs", 32'(w_all), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Plain pass: contiguous beats, first beat two cycles after start.
    pulse_start();
    wait_done();
    check_pass("pass1", s_cyc + 2, 672);

    // Back-pressure raised at issue 85 (row 3, f=2, kr=1). Filter 2 still
    // completes. Issue 90 (filter 3) then waits the 15 cycles that dst_full
    // stays high.
    pulse_start();
    wait_cyc(s_cyc + 86);
    dst_full = 1'b1;
    wait_cyc(s_cyc + 106);
    dst_full = 1'b0;
    wait_done();
    check_pass("stall", s_cyc + 2, 672 + 15);
    check("stall_at_filter_edge", 32'(gap_beat), 32'd90);

    // Asynchronous reset mid-pass, then a clean full pass.
    pulse_start();
    wait_cyc(s_cyc + 300);
    #3;
    rst = 1'b0;
    #1;
    check("midpass_reset_outs", 32'(w_all), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    pulse_start();
    wait_done();
    check_pass("after_reset", s_cyc + 2, 672);

    // A start in RUN and a start on the done cycle are both ignored. A start
    // held into the following IDLE cycle begins the next pass.
    pulse_start();
    wait_cyc(s_cyc + 100);
    start = 1'b1;
    wait_cyc(s_cyc + 101);
    start = 1'b0;
    d = s_cyc + 674;
    wait_cyc(d);
    start = 1'b1;
    wait_cyc(d + 1);
    check("restart_done_at", 32'(done_cyc), 32'(d));
    check("restart_pass_beats", 32'(en_count), 32'd672);
    check("restart_done_once", 32'(done_cnt), 32'd1);
    new_pass();
    wait_cyc(d + 2);
    start = 1'b0;
    wait_done();
    check_pass("restart", d + 3, 672);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
